// File: rtl/inverse_pi_unit_pkg.sv
// Shared constants for the 5x5 page permutation datapath.
// Page geometry, counter widths and FSM state encoding.
package inverse_pi_unit_pkg;

    localparam int SIZE_PAGE        = 25;
    localparam int LEN_DATA         = SIZE_PAGE;
    localparam int NUM_PAGE         = 64;
    localparam int LEN_COUNTER_DATA = $clog2(NUM_PAGE + 1);
    localparam int LEN_INDEX        = 5;

    localparam logic [LEN_INDEX-1:0] LAST_BIT = 5'd24;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_SHUFFLE = 3'd2;
    localparam logic [2:0] ST_EMIT    = 3'd3;
    localparam logic [2:0] ST_FIN     = 3'd4;

    function automatic logic [LEN_INDEX-1:0] mod5(input logic [LEN_INDEX-1:0] x);
        return x % 5'd5;
    endfunction

endpackage

// File: rtl/inverse_pi_index.sv
// Bit-counter to source/destination index map for the inverse page shuffle.
// dst = i*5 + j, src = i*5 + (2i + 3j) mod 5, with i = k mod 5, j = k / 5.
module inverse_pi_index
    import inverse_pi_unit_pkg::*;
(
    input  logic [LEN_INDEX-1:0] k_i,
    output logic [LEN_INDEX-1:0] src_index_o,
    output logic [LEN_INDEX-1:0] dst_index_o
);

    logic [LEN_INDEX-1:0] row;
    logic [LEN_INDEX-1:0] col;
    logic [LEN_INDEX-1:0] sum;

    always_comb begin
        row = mod5(k_i);
        col = k_i / 5'd5;
        // 2i + 3j peaks at 20, so it fits the 5-bit index width
        sum = (row << 1) + (col << 1) + col;
        src_index_o = (row << 2) + row + mod5(sum);
        dst_index_o = (row << 2) + row + col;
    end

endmodule

// File: rtl/inverse_pi_unit.sv
// Streaming un-permutation engine: restores original bit order of 5x5 pages,
// one bit per cycle, over a frame of NUM_PAGE pages.
module inverse_pi_unit
    import inverse_pi_unit_pkg::*;
#(
    parameter int NUM_PAGE = inverse_pi_unit_pkg::NUM_PAGE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LEN_DATA-1:0] data_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LEN_DATA-1:0] data_out,
    output logic                busy,
    output logic                done
);

    localparam int CW = $clog2(NUM_PAGE + 1);
    localparam logic [CW-1:0] PAGE_LAST = CW'(NUM_PAGE);

    logic [2:0]           state_q, state_d;
    logic [LEN_INDEX-1:0] k_q, k_d;
    logic [CW-1:0]        page_q, page_d, page_inc;
    logic [LEN_DATA-1:0]  in_q, in_d;
    logic [LEN_DATA-1:0]  out_q, out_d;
    logic [LEN_INDEX-1:0] src_idx, dst_idx;

    inverse_pi_index u_index (
        .k_i         (k_q),
        .src_index_o (src_idx),
        .dst_index_o (dst_idx)
    );

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        page_d   = page_q;
        in_d     = in_q;
        out_d    = out_q;
        page_inc = page_q + 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (in_valid) begin
                    in_d    = data_in;
                    out_d   = '0;
                    k_d     = '0;
                    state_d = ST_SHUFFLE;
                end
            end
            ST_SHUFFLE: begin
                out_d[dst_idx] = in_q[src_idx];
                k_d = k_q + 1'b1;
                if (k_q == LAST_BIT) state_d = ST_EMIT;
            end
            ST_EMIT: begin
                if (out_ready) begin
                    page_d  = page_inc;
                    state_d = (page_inc == PAGE_LAST) ? ST_FIN : ST_LOAD;
                end
            end
            ST_FIN: begin
                page_d  = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            page_q  <= '0;
            in_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            page_q  <= page_d;
            in_q    <= in_d;
            out_q   <= out_d;
        end
    end

    // All handshake outputs decode registered state only
    assign in_ready  = (state_q == ST_LOAD);
    assign out_valid = (state_q == ST_EMIT);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FIN);
    assign data_out  = out_q;

endmodule

// File: doc/inverse_pi_unit.md
# inverse_pi_unit

Streaming un-permutation engine for 5x5 bit-slice pages: accepts pages in which bit (i, j) has been moved to row i, column (2i + 3j) mod 5, and restores each bit to position i*5 + j. It sits on the read-back side of the page-permutation datapath. Its output pages feed consumers that need original bit order, such as the verification scoreboard and the host read path. It processes a fixed-length frame of pages using an internal FSM, a page counter and a per-bit counter, with valid/ready handshakes on both sides.

## Interface
- NUM_PAGE, 64, pages per frame (frame ends after this many pages are emitted)
- SIZE_PAGE, 25, bits per page (fixed 5x5; other values unsupported)
- clk  in  1  rising-edge clock
- rst  in  1  reset: asynchronous, active-high; clears all state
- start  in  1  one-cycle pulse; begins a frame (ignored unless IDLE)
- in_valid  in  1  input page available
- in_ready  out  1  engine accepts a page this cycle
- data_in  in  SIZE_PAGE  permuted page, bit index i*5 + y
- out_valid  out  1  restored page valid on data_out
- out_ready  in  1  consumer accepts the page
- data_out  out  SIZE_PAGE  restored page, bit index i*5 + j
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the last page of the frame is emitted

## Operation
- Mapping: data_out[i*5 + j] = in_page[i*5 + ((2i + 3j) mod 5)], with i = k mod 5, j = k / 5, and k = 0..24. The mapping is a permutation within each row. It is the exact inverse of the forward map out[i*5 + (2i+3j) mod 5] = in[i*5 + j].
- One bit is moved per cycle. Bit counter k is 5 bits wide and runs 0..24. Source and destination indices are computed combinationally from k at 5-bit width. The mod-5 reduction is applied to a sum of at most 20.
- Page counter is ceil(log2(NUM_PAGE+1)) bits wide, 0..NUM_PAGE.
- FSM states and transitions:
  - IDLE → LOAD on start.
  - LOAD: in_ready = 1. On in_valid & in_ready, capture data_in into the input register, clear the output register, clear k, and go to SHUFFLE.
  - SHUFFLE: each cycle, write one destination bit and increment k. When k = 24 the bit is written and the FSM goes to EMIT.
  - EMIT: out_valid = 1 and data_out holds the output register. On out_ready, increment the page counter. If the new count equals NUM_PAGE, go to FIN; otherwise go to LOAD.
  - FIN: done = 1 for one cycle, then return to IDLE and clear the page counter.
- start outside IDLE is ignored. in_valid outside LOAD is not acknowledged; data is held by the producer.
- Reset mid-frame aborts the frame with no done pulse. A partially shuffled page is discarded.

## Timing
- Reset values: in_ready=0, out_valid=0, busy=0, done=0, data_out=0, state=IDLE, and both counters 0.
- busy = 1 in LOAD, SHUFFLE, EMIT and FIN.
- start is sampled at edge t, so LOAD begins at t+1. in_ready is high from that cycle.
- Per-page latency is measured from the handshake edge. SHUFFLE occupies 25 cycles. out_valid rises on the 26th cycle after input acceptance.
- Best-case throughput is 27 cycles per page: 1 load, 25 shuffle, 1 emit.
- out_valid and data_out stay stable while out_ready = 0, with no timeout.
- done asserts the cycle after the final EMIT handshake, for exactly one cycle. in_ready stays 0 in FIN.
- No combinational path runs from in_valid to in_ready, or from out_ready to out_valid.

## Structure
- The shared ISA include holds LEN_DATA (SIZE_PAGE), SIZE_PAGE, NUM_PAGE, LEN_COUNTER_DATA, LEN_INDEX and the FSM state encoding. These are shared with the forward datapath.
- One natural sub-module is inverse_pi_index. It is combinational: k in, src_index and dst_index out. The bench reuses it as a golden model.
- Counter and Register are reused from the existing library.

## Test plan
- Single-bit pages: 25'h0000001 → 25'h0000001; bit 1 → bit 2; bit 5 → bit 6; bit 24 → bit 22. Each output appears 26 cycles after acceptance.
- Round trip: 64 random pages go through the forward datapath, then this block. Each output equals its original page, and done pulses exactly once after page 64.
- Backpressure: hold out_ready = 0 for 10 cycles in EMIT. out_valid and data_out stay stable, and in_ready stays 0 until the handshake.
- Input stall: hold in_valid = 0 for 7 cycles in LOAD. No shuffle occurs, the page counter is unchanged, and the data is captured correctly on the eventual handshake.
- Async reset during SHUFFLE at k = 12: all outputs drop to reset values immediately, without waiting for a clock edge. A subsequent start and full frame complete correctly.
- start pulsed during EMIT is ignored. With NUM_PAGE = 1, done follows the single emit, and a start issued in IDLE afterwards begins a new frame.
